// File: rtl/ppbuf_pkg.sv
// ppbuf_pkg: shared constants, types and helpers for the ping-pong SRAM buffer.
//   BANK_CNT   : number of banks (fixed at two, ping and pong)
//   LEVEL_W    : width of the committed-bank count (0..2)
//   bank_idx_t : bank index type used for the producer/consumer pointers
//   full_count : number of banks currently holding committed data
package ppbuf_pkg;

  localparam int BANK_CNT = 2;
  localparam int LEVEL_W  = 2;

  typedef logic bank_idx_t;

  function automatic logic [LEVEL_W-1:0] full_count(input logic [BANK_CNT-1:0] full);
    full_count = {1'b0, full[0]} + {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/sram_bank_1r1w.sv
// sram_bank_1r1w: one SRAM bank with a single write port and a single
// registered read port (read latency 1).
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset; clears only the read data register,
//           never the array contents
//   we    : write enable (caller guarantees waddr < DEPTH)
//   waddr : write address
//   wdata : write data
//   re    : read enable (caller guarantees raddr < DEPTH)
//   raddr : read address
//   rdata : registered read data; holds its value when re is low
module sram_bank_1r1w #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array has no reset so it maps onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register: reset to zero, otherwise only updates on a read so
  // the last returned word stays on the bus between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pingpong_sram_buffer.sv
// pingpong_sram_buffer: double-buffered SRAM between a producer (tile loader)
// and a consumer (systolic array feeder). The producer fills one bank while
// the consumer drains the other; ownership swaps automatically on
// commit/release, so there is no external bank select.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : write a word into the current fill bank
//   wr_commit             : producer hands the fill bank to the consumer
//   wr_ready              : fill bank is free for writing
//   rd_en/rd_addr         : read a word from the current drain bank
//   rd_data/rd_valid      : registered read result, one cycle after rd_en
//   rd_ready              : drain bank holds committed data
//   rd_release            : consumer returns the drain bank to the producer
//   wr_bank/rd_bank       : bank indices owned by producer / consumer
//   level                 : committed banks awaiting release (0..2)
//   err_overrun/underrun  : sticky error flags, present only when the
//                           PPBUF_ERR_EN macro is defined
//
// Handshake: a request (wr_en, wr_commit, rd_en, rd_release) takes effect
// only in a cycle where the matching ready (wr_ready for the producer side,
// rd_ready for the consumer side) is high at the sampling edge; requests
// made while ready is low are dropped, never queued. Ready signals are
// combinational from registered state and never depend on the requests.
module pingpong_sram_buffer
  import ppbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_ready,
  input  logic                  rd_release,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [LEVEL_W-1:0]    level
`ifdef PPBUF_ERR_EN
  ,
  output logic                  err_overrun,
  output logic                  err_underrun
`endif
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [BANK_CNT-1:0] bank_full;
  logic [BANK_CNT-1:0] bank_full_next;
  bank_idx_t           wr_ptr;
  bank_idx_t           rd_ptr;
  bank_idx_t           rd_sel;   // bank whose output register drives rd_data

  logic wr_in_range;
  logic rd_in_range;
  logic wr_fire;
  logic commit_fire;
  logic rd_fire;
  logic release_fire;

  logic [BANK_CNT-1:0]   bank_we;
  logic [BANK_CNT-1:0]   bank_re;
  logic [DATA_WIDTH-1:0] bank_rdata [BANK_CNT];

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  assign wr_ready = !bank_full[wr_ptr];
  assign rd_ready = bank_full[rd_ptr];

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

  assign wr_fire      = wr_en && wr_ready && wr_in_range;
  assign commit_fire  = wr_commit && wr_ready;
  assign rd_fire      = rd_en && rd_ready && rd_in_range;
  assign release_fire = rd_release && rd_ready;

  assign wr_bank = wr_ptr;
  assign rd_bank = rd_ptr;
  assign level   = full_count(bank_full);

  // ---------------------------------------------------------------------
  // Bank storage. A write in the same cycle as its commit still targets
  // wr_ptr (the pointer only moves at the edge), and a read in the same
  // cycle as its release still targets rd_ptr, so both land in the bank
  // being handed over.
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (wr_ptr == bank_idx_t'(b));
    assign bank_re[b] = rd_fire && (rd_ptr == bank_idx_t'(b));

    sram_bank_1r1w #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bank_re[b]),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Both output registers reset to zero and rd_sel resets to 0, so rd_data
  // reads zero out of reset and otherwise holds the last returned word.
  assign rd_data = bank_rdata[rd_sel];

  // ---------------------------------------------------------------------
  // Ownership flags. A commit needs its bank empty and a release needs its
  // bank full, so in a cycle where both fire they touch different banks.
  // ---------------------------------------------------------------------
  always_comb begin
    bank_full_next = bank_full;
    if (commit_fire) begin
      bank_full_next[wr_ptr] = 1'b1;
    end
    if (release_fire) begin
      bank_full_next[rd_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_sel    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      bank_full <= bank_full_next;
      if (commit_fire) begin
        wr_ptr <= ~wr_ptr;
      end
      if (release_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_sel <= rd_ptr;
      end
    end
  end

`ifdef PPBUF_ERR_EN
  // ---------------------------------------------------------------------
  // Sticky protocol errors: a request while the side is not ready. An
  // out-of-range address alone is not treated as an error.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if ((wr_en || wr_commit) && !wr_ready) begin
        err_overrun <= 1'b1;
      end
      if ((rd_en || rd_release) && !rd_ready) begin
        err_underrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_sram_buffer.sv
// tb_pingpong_sram_buffer: directed self-checking bench for
// pingpong_sram_buffer with DEPTH=200, ADDR_WIDTH=8, DATA_WIDTH=8, so the
// first out-of-range address (200) is still encodable. Error flag checks
// are compiled in only when PPBUF_ERR_EN is defined.
module tb_pingpong_sram_buffer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DP = 200;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic          wr_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_release;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    level;
`ifdef PPBUF_ERR_EN
  logic          err_overrun;
  logic          err_underrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pingpong_sram_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_release (rd_release),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .level      (level)
`ifdef PPBUF_ERR_EN
    ,
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_commit  = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic commit);
    wr_en     = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    wr_commit = commit;
  endtask

  task automatic read(input logic [AW-1:0] a, input logic release_bank);
    rd_en      = 1'b1;
    rd_addr    = a;
    rd_release = release_bank;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    cycle();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_rd_ready", 32'(rd_ready), 32'd0);
    check_eq("rst_level",    32'(level),    32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data",  32'(rd_data),  32'h0);
    check_eq("rst_wr_bank",  32'(wr_bank),  32'd0);
    check_eq("rst_rd_bank",  32'(rd_bank),  32'd0);
`ifdef PPBUF_ERR_EN
    check_eq("rst_err_ov", 32'(err_overrun),  32'd0);
    check_eq("rst_err_un", 32'(err_underrun), 32'd0);
`endif

    // Basic fill/commit/read: 0xA5 @3 in bank0
    write(8'd3, 8'hA5, 1'b0);
    cycle();
    check_eq("fill0_rd_ready", 32'(rd_ready), 32'd0);
    wr_commit = 1'b1;
    cycle();
    check_eq("commit0_wr_bank", 32'(wr_bank),  32'd1);
    check_eq("commit0_rd_ready",32'(rd_ready), 32'd1);
    check_eq("commit0_level",   32'(level),    32'd1);
    check_eq("commit0_wr_ready",32'(wr_ready), 32'd1);
    read(8'd3, 1'b0);
    cycle();
    check_eq("rd0_data",  32'(rd_data),  32'hA5);
    check_eq("rd0_valid", 32'(rd_valid), 32'd1);
    check_eq("rd0_bank",  32'(rd_bank),  32'd0);
    check_eq("rd0_wbank", 32'(wr_bank),  32'd1);
    cycle();
    check_eq("rd0_idle_valid", 32'(rd_valid), 32'd0);
    check_eq("rd0_idle_hold",  32'(rd_data),  32'hA5);

    // Same-cycle write+commit into bank1 -> both banks full
    write(8'd3, 8'h77, 1'b1);
    cycle();
    check_eq("full_level",    32'(level),    32'd2);
    check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("full_wr_bank",  32'(wr_bank),  32'd0);
    // Producer stalled: write and commit both dropped
    write(8'd3, 8'hFF, 1'b1);
    cycle();
    check_eq("stall_level",   32'(level),   32'd2);
    check_eq("stall_wr_bank", 32'(wr_bank), 32'd0);
`ifdef PPBUF_ERR_EN
    check_eq("stall_err_ov", 32'(err_overrun), 32'd1);
`endif
    read(8'd3, 1'b0);
    cycle();
    check_eq("stall_bank0_intact", 32'(rd_data), 32'hA5);
    rd_release = 1'b1;
    cycle();
    check_eq("rel0_rd_bank",  32'(rd_bank),  32'd1);
    check_eq("rel0_level",    32'(level),    32'd1);
    check_eq("rel0_wr_ready", 32'(wr_ready), 32'd1);
    read(8'd3, 1'b0);
    cycle();
    check_eq("bank1_data",  32'(rd_data),  32'h77);
    check_eq("bank1_valid", 32'(rd_valid), 32'd1);

    // Same-cycle read+release: 0x3C @5 in bank0
    write(8'd5, 8'h3C, 1'b1);
    cycle();
    check_eq("b0_again_level", 32'(level), 32'd2);
    rd_release = 1'b1;                         // drop bank1
    cycle();
    check_eq("rel1_rd_bank", 32'(rd_bank), 32'd0);
    check_eq("rel1_level",   32'(level),   32'd1);
    read(8'd5, 1'b1);
    cycle();
    check_eq("rdrel_data",     32'(rd_data),  32'h3C);
    check_eq("rdrel_valid",    32'(rd_valid), 32'd1);
    check_eq("rdrel_rd_ready", 32'(rd_ready), 32'd0);
    check_eq("rdrel_level",    32'(level),    32'd0);
    check_eq("rdrel_rd_bank",  32'(rd_bank),  32'd1);

    // Same-cycle commit + release on different banks
    write(8'd0, 8'h11, 1'b1);                  // bank1
    cycle();
    check_eq("c1_rd_ready", 32'(rd_ready), 32'd1);
    write(8'd0, 8'h22, 1'b1);                  // bank0
    rd_release = 1'b1;                         // bank1
    cycle();
    check_eq("cr_level",    32'(level),    32'd1);
    check_eq("cr_rd_bank",  32'(rd_bank),  32'd0);
    check_eq("cr_wr_bank",  32'(wr_bank),  32'd1);
    check_eq("cr_rd_ready", 32'(rd_ready), 32'd1);
    read(8'd0, 1'b0);
    cycle();
    check_eq("cr_data", 32'(rd_data), 32'h22);

    // Underrun: release bank0, then read with nothing committed
    rd_release = 1'b1;
    cycle();
    check_eq("empty_level", 32'(level), 32'd0);
    read(8'd0, 1'b0);
    cycle();
    check_eq("under_valid", 32'(rd_valid), 32'd0);
    check_eq("under_hold",  32'(rd_data),  32'h22);
`ifdef PPBUF_ERR_EN
    check_eq("under_err", 32'(err_underrun), 32'd1);
    cycle();
    check_eq("under_err_sticky", 32'(err_underrun), 32'd1);
`endif

    // Address boundary: 199 valid, 200 out of range
    write(8'd199, 8'h66, 1'b1);                // bank1
    cycle();
    write(8'd200, 8'h99, 1'b0);                // bank0, dropped
    cycle();
    check_eq("oor_wr_level", 32'(level), 32'd1);
    read(8'd200, 1'b0);
    cycle();
    check_eq("oor_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("oor_rd_hold",  32'(rd_data),  32'h22);
    read(8'd199, 1'b0);
    cycle();
    check_eq("last_addr_data",  32'(rd_data),  32'h66);
    check_eq("last_addr_valid", 32'(rd_valid), 32'd1);

    // Reset mid-drain with a read request in the reset cycle
    read(8'd199, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("mrst_valid",    32'(rd_valid), 32'd0);
    check_eq("mrst_data",     32'(rd_data),  32'h0);
    check_eq("mrst_level",    32'(level),    32'd0);
    check_eq("mrst_rd_ready", 32'(rd_ready), 32'd0);
    check_eq("mrst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("mrst_wr_bank",  32'(wr_bank),  32'd0);
    check_eq("mrst_rd_bank",  32'(rd_bank),  32'd0);
`ifdef PPBUF_ERR_EN
    check_eq("mrst_err_ov", 32'(err_overrun),  32'd0);
    check_eq("mrst_err_un", 32'(err_underrun), 32'd0);
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_sram_buffer.md
# pingpong_sram_buffer

Parametrised ping-pong (double-buffered) SRAM with independent producer write port and consumer read port, plus automatic bank-swap handshake. Producer fills one bank while consumer drains the other; banks swap ownership on commit/release with no external bank-select. Sits between the tile loader and the systolic array feeders, replacing manual bank selection in the single-port double buffer.

## Interface
- ADDR_WIDTH, 8, address width per bank
- DATA_WIDTH, 8, word width
- DEPTH, 256, words per bank; DEPTH ≤ 2**ADDR_WIDTH

- clk  in  1  single clock, all logic posedge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write word into current fill bank
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_commit  in  1  producer finished fill bank; hand it to consumer
- wr_ready  out  1  fill bank free for writing
- rd_en  in  1  read request from current drain bank
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  rd_data valid this cycle
- rd_ready  out  1  drain bank holds committed data
- rd_release  in  1  consumer finished drain bank; return it to producer
- wr_bank  out  1  bank index currently owned by producer
- rd_bank  out  1  bank index currently owned by consumer
- level  out  2  committed banks awaiting release (0..2)
- err_overrun, err_underrun  out  1 each  only with PPBUF_ERR_EN (see Configuration)

## Operation
- State: bank_full[1:0], wr_ptr, rd_ptr (1 bit each). wr_bank=wr_ptr, rd_bank=rd_ptr.
- wr_ready = !bank_full[wr_ptr]; rd_ready = bank_full[rd_ptr]; level = bank_full[0]+bank_full[1].
- Write accepted when wr_en && wr_ready && wr_addr < DEPTH; otherwise dropped, memory unchanged.
- Commit accepted when wr_commit && wr_ready: bank_full[wr_ptr]←1, wr_ptr toggles. Ignored otherwise.
- Read accepted when rd_en && rd_ready && rd_addr < DEPTH; otherwise rd_valid=0 next cycle, rd_data holds.
- Release accepted when rd_release && rd_ready: bank_full[rd_ptr]←0, rd_ptr toggles. Ignored otherwise.
- Same-cycle write + commit: write lands in bank being committed, then commit.
- Same-cycle read + release: read returns data from bank being released.
- Same-cycle commit + release: always different banks; both take effect.
- Both banks full: wr_ready=0, producer stalls. Both empty: rd_ready=0, consumer stalls.
- Ownership strictly alternates 0,1,0,1; producer never writes a bank the consumer holds.

## Timing
- Write: 1 cycle, data visible to reads after commit.
- Read latency 1: rd_en accepted at cycle N → rd_data/rd_valid at N+1. Back-to-back reads every cycle.
- Flags, pointers, level update at the edge after the commit/release cycle; wr_ready/rd_ready combinational from registered state.
- Commit at N → rd_ready=1 at N+1 (if consumer idle on that bank).
- Reset (rst_n=0 at edge): bank_full=0, wr_ptr=rd_ptr=0, rd_data=0, rd_valid=0, level=0, errs=0; wr_ready=1, rd_ready=0. Memory contents not cleared. Mid-operation reset discards all committed data; in-flight read returns rd_valid=0.

## Configuration
- PPBUF_ERR_EN defined: err_overrun sticky-set on wr_en or wr_commit while !wr_ready; err_underrun sticky-set on rd_en or rd_release while !rd_ready; cleared only by reset. Out-of-range address not an error.
- Undefined: ports absent, illegal requests silently ignored; functional behaviour otherwise identical.

## Structure
- Package ppbuf_pkg: BANK_CNT=2, LEVEL_W=2 constants, bank_idx_t typedef.
- Sub-module sram_bank_1r1w (one write port, one registered read port, params ADDR_WIDTH/DATA_WIDTH/DEPTH), instantiated twice; top holds flags, pointers, read mux, error logic.

## Test plan
- Reset → wr_ready=1, rd_ready=0, level=0, rd_valid=0, wr_bank=rd_bank=0.
- Write 0xA5@3 to bank0, commit, rd_en@3 → next cycle rd_data=0xA5, rd_valid=1, rd_bank=0, wr_bank=1.
- Commit bank0 and bank1 without release → level=2, wr_ready=0; write 0xFF@3 dropped; release → read bank1 data intact, wr_ready=1.
- rd_en with level=0 → rd_valid=0, rd_data unchanged; with PPBUF_ERR_EN err_underrun=1 and stays 1.
- Same-cycle rd_en@5 + rd_release on bank holding 0x3C@5 → rd_data=0x3C next cycle, rd_ready reflects other bank.
- wr_addr=DEPTH with DEPTH=200, ADDR_WIDTH=8 → no write; reset mid-drain → level=0, rd_valid=0 next cycle.
